// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one async SRAM between the fetch and data ports with fixed wait states
// Optional round-robin conflict resolution: define SRAM_ARB_RR_EN (default build uses fixed data-first priority).
module sram_bus_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_stall_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_stall_o,
  input  logic              flush_i,
  output logic              sram_ce_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;
  localparam int   CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t              state, state_nxt;
  logic                grant, grant_nxt;
  logic                last_grant;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [3:0]          lat_sel;
  logic [31:0]         lat_wdata;
  logic                pick_data;

`ifdef SRAM_ARB_RR_EN
  // On a conflict the port that did not win last time goes first.
  assign pick_data = mem_ce_i & (!if_ce_i | (last_grant == GRANT_INST));
`else
  assign pick_data = mem_ce_i;
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (mem_ce_i || if_ce_i) begin
          state_nxt = ACCESS;
          grant_nxt = pick_data ? GRANT_DATA : GRANT_INST;
        end
      end
      ACCESS: begin
        // A flushed fetch is discarded; a data access must finish to keep memory consistent.
        if (flush_i && (grant == GRANT_INST)) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GRANT_INST;
      last_grant <= GRANT_INST;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_sel    <= 4'h0;
      lat_wdata  <= 32'h0;
      if_data_o  <= 32'h0;
      mem_data_o <= 32'h0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == IDLE && state_nxt == ACCESS) begin
        cnt <= '0;
        if (pick_data) begin
          lat_addr  <= mem_addr_i[ADDR_W+1:2];
          lat_we    <= mem_we_i;
          lat_sel   <= mem_sel_i;
          lat_wdata <= mem_data_i;
        end else begin
          lat_addr  <= if_addr_i[ADDR_W+1:2];
          lat_we    <= 1'b0;
          lat_sel   <= 4'hF;
        end
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
        if (state_nxt == DONE) begin
          last_grant <= grant;
          if (!lat_we) begin
            if (grant == GRANT_INST) if_data_o  <= sram_rdata_i;
            else                     mem_data_o <= sram_rdata_i;
          end
        end
      end
    end
  end

  assign sram_ce_n_o  = (state != ACCESS);
  assign sram_we_n_o  = !((state == ACCESS) && lat_we);
  assign sram_be_n_o  = (state != ACCESS) ? 4'hF : (lat_we ? ~lat_sel : 4'h0);
  assign sram_addr_o  = lat_addr;
  assign sram_wdata_o = lat_wdata;

  assign if_stall_o  = !rst && if_ce_i  && !((state == DONE) && (grant == GRANT_INST));
  assign mem_stall_o = !rst && mem_ce_i && !((state == DONE) && (grant == GRANT_DATA));

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Shares one external single-port 32-bit asynchronous SRAM between the instruction-fetch port and the data port of the memory-access stage. Both ports keep their existing interfaces. The block sequences each access through a fixed wait-state count and raises per-port stall requests to the pipeline controller until that port's access completes. It sits between if/mem stage outputs and the SRAM pins.

Parameters:
ADDR_W, 20, SRAM word-address width; sram_addr_o = addr_i[ADDR_W+1:2]
WAIT_CYCLES, 2, cycles the SRAM is driven per access (>=1); read data sampled in the last one

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset (`RstEnable` = 1'b1)
if_ce_i  in  1  instruction fetch request
if_addr_i  in  32  fetch byte address
if_data_o  out  32  fetched instruction, registered
if_stall_o  out  1  stall request for fetch side
mem_ce_i  in  1  data access request
mem_we_i  in  1  1 = write, 0 = read (already exception-masked upstream)
mem_sel_i  in  4  byte lane select, bit3 = bits[31:24]
mem_addr_i  in  32  data byte address
mem_data_i  in  32  write data
mem_data_o  out  32  read data, registered
mem_stall_o  out  1  stall request for memory stage
flush_i  in  1  pipeline flush (exception/eret)
sram_ce_n_o  out  1  SRAM chip enable, active low
sram_we_n_o  out  1  SRAM write enable, active low
sram_be_n_o  out  4  SRAM byte enables, active low
sram_addr_o  out  ADDR_W  SRAM word address
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data

Behaviour:
- States: IDLE, ACCESS, DONE. Registers: state, grant (INST/DATA), wait counter, latched addr/we/sel/wdata, last_grant.
- Reset (synchronous): state=IDLE; sram_ce_n_o=1, sram_we_n_o=1, sram_be_n_o=4'hF, sram_addr_o=0, sram_wdata_o=0; if_data_o=0, mem_data_o=0; counter=0; last_grant=INST; if_stall_o=mem_stall_o=0 while rst=1.
- IDLE: if mem_ce_i, grant=DATA. Else if if_ce_i, grant=INST. Latch the request fields, counter=0, go to ACCESS. No request: stay in IDLE, SRAM pins idle.
- ACCESS: sram_ce_n_o=0. For reads: sram_we_n_o=1, sram_be_n_o=4'b0000. For writes: sram_we_n_o=0, sram_be_n_o=~sel, sram_wdata_o=latched data. Counter increments each cycle. When counter==WAIT_CYCLES-1, capture sram_rdata_i into if_data_o or mem_data_o (reads only), set last_grant=grant, and go to DONE.
- DONE: SRAM pins idle (ce_n=1, we_n=1, be_n=F). Unconditionally return to IDLE next cycle.
- Stall rules (combinational from registered state):
  - if_stall_o = if_ce_i & !(state==DONE & grant==INST)
  - mem_stall_o = mem_ce_i & !(state==DONE & grant==DATA)
- Latency: an uncontended access completes in WAIT_CYCLES+2 cycles from request to stall release.
- Data outputs hold their value until the next completed read on the same port. Writes leave mem_data_o unchanged.
- Both requests in the same IDLE cycle: resolved per Optional Feature. The loser stays stalled and is served on the next IDLE.
- A request arriving mid-access is not latched until the next IDLE; addresses must stay stable while stalled.
- flush_i:
  - In ACCESS with grant=INST: abort. Next state=IDLE, pins idle, if_data_o unchanged, last_grant unchanged.
  - In ACCESS with grant=DATA: ignored; the access completes.
  - In IDLE or DONE: no effect.
- Request dropped while its own access is in flight: the access still completes.
- WAIT_CYCLES=1: ACCESS lasts exactly one cycle.

Optional Feature:
SRAM_ARB_RR_EN defined:
- On simultaneous requests in IDLE, grant goes to the port opposite last_grant (round-robin).
- After reset the first conflict goes to DATA.
Not defined:
- Fixed priority: DATA always beats INST. last_grant is still maintained but unused.

Test Plan:
- Reset with all requests high, rst=1 for 3 cycles -> sram_ce_n_o=1, be_n=4'hF, both stalls 0, data outputs 0.
- if_ce_i=1, addr 0x00000010, sram_rdata_i=0x3C011234, WAIT_CYCLES=2 -> sram_addr_o=0x4 for 2 cycles, if_stall_o high 3 cycles then low 1 cycle, if_data_o=0x3C011234.
- mem write: sel=4'b0011, addr 0x0000010A, data 0x0000BEEF -> sram_we_n_o=0, be_n=4'b1100, sram_addr_o=0x42 for 2 cycles, mem_data_o unchanged.
- Both requests in the same cycle, macro off -> DATA served first, INST served next, fetch stall released 8 cycles after request. Macro on, after a prior DATA access -> INST served first.
- Fetch in ACCESS, flush_i pulsed in first ACCESS cycle -> IDLE next cycle, sram_ce_n_o=1, if_data_o unchanged. Same flush during a data read -> read completes normally.
- Back-to-back mem reads at 0x0 then 0x4 with if_ce_i held high, macro off -> the two DATA accesses are separated by IDLE. INST wins the IDLE only if mem_ce_i is low in that cycle; otherwise the fetch stall persists (no fairness without the macro).
